// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing derivation,
// reused by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // The counter must reach SYMBOL_EDGE_TIME-1 without wrapping; keep at least one bit.
  function automatic int cnt_width(input int symbol_cycles);
    return (symbol_cycles > 1) ? $clog2(symbol_cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: counts while running, clears at each bit boundary,
// and pulses bit_done_o on the last cycle of a bit.
module uart_bit_timer #(
  parameter int SYMBOL_CYCLES = 434,
  parameter int CNT_W         = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic bit_done_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done_o = run_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || bit_done_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a valid/ready byte input and a registered serial line.
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | driving start bit (0)
//   DATA  | shifting out data bits, LSB first
//   STOP  | driving stop bit (1)
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W            = cnt_width(SYMBOL_EDGE_TIME);

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        serial_q;
  logic        bit_done;
  logic        handshake;

  assign data_in_ready = (state_q == IDLE);
  assign handshake     = data_in_valid && data_in_ready;
  assign serial_out    = serial_q;

  uart_bit_timer #(
    .SYMBOL_CYCLES(SYMBOL_EDGE_TIME),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run_i     (state_q != IDLE),
    .bit_done_o(bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          serial_q <= 1'b1;
          if (handshake) begin
            shift_q   <= data_in;
            bit_idx_q <= '0;
            serial_q  <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            serial_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == 3'd7) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              serial_q  <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          serial_q <= 1'b1;
          if (bit_done) state_q <= IDLE;
        end
        default: begin
          serial_q <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: the driver queues each accepted byte,
// a line monitor checks every cycle of the resulting 8N1 frame against it.
module tb_uart_transmitter;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115_200;
  localparam int S      = CLK_HZ / BAUD;
  localparam time TCLK  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;

  typedef struct {
    logic [7:0] data;
    time        t_hs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_busy = 1'b0;

  always #(TCLK/2) clk = ~clk;

  uart_transmitter #(
    .CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Present a byte at a falling edge and wait for the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, output time t_hs);
    int n;
    @(negedge clk);
    data_in       = b;
    data_in_valid = 1'b1;
    n = 0;
    while (data_in_ready !== 1'b1 && n < 12*S) begin
      @(negedge clk);
      n++;
    end
    t_hs = $time;
    if (data_in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_%02h: ready never rose, got %b expected 1", b, data_in_ready);
    end else begin
      exp_q.push_back('{data: b, t_hs: $time});
    end
  endtask

  task automatic release_valid();
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 12*S) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || mon_busy) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: frame not finished, pending %0d expected 0", name, exp_q.size());
    end
  endtask

  // Line monitor: a frame begins at the first low sample; each of the 10*S
  // samples must match the ideal frame and ready must stay low throughout.
  initial begin
    exp_t       e;
    logic [9:0] frame;
    logic [7:0] decoded;
    logic       line_ok;
    bit         aborted;
    time        t0;
    forever begin
      @(negedge clk);
      if (rst || serial_out !== 1'b0) continue;
      t0 = $time;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: start bit at %0t with nothing queued", t0);
        repeat (10*S - 1) @(negedge clk);
        continue;
      end
      e        = exp_q.pop_front();
      mon_busy = 1'b1;
      frame    = {1'b1, e.data, 1'b0};
      decoded  = '0;
      line_ok  = 1'b1;
      aborted  = 1'b0;
      for (int k = 0; k < 10*S; k++) begin
        if (k > 0) @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        if (serial_out !== frame[k/S]) line_ok = 1'b0;
        if (data_in_ready !== 1'b0)    line_ok = 1'b0;
        if ((k % S) == S/2 && k/S >= 1 && k/S <= 8) decoded[k/S - 1] = serial_out;
      end
      if (!aborted) begin
        @(negedge clk);
        if (!rst && data_in_ready !== 1'b1) line_ok = 1'b0;
        vectors++;
        if (!line_ok || t0 != e.t_hs + TCLK) begin
          miscompares++;
          $display("FAIL frame_%02h: decoded %02h start %0t, expected %02h start %0t (ok=%b)",
                   e.data, decoded, t0, e.data, e.t_hs + TCLK, line_ok);
        end
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    time  t1, t2;
    logic idle_ok;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(data_in_ready), 32'd1);
    check("reset_serial", 32'(serial_out), 32'd1);
    #2 rst = 1'b0;

    idle_ok = 1'b1;
    repeat (10_000) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || data_in_ready !== 1'b1) idle_ok = 1'b0;
    end
    check("idle_10000", 32'(idle_ok), 32'd1);

    send_byte(8'hA5, t1);
    release_valid();
    wait_done("a5");

    send_byte(8'h00, t1);
    send_byte(8'hFF, t2);
    release_valid();
    check("b2b_gap", 32'((t2 - t1) / TCLK), 32'(10*S + 1));
    wait_done("b2b");

    send_byte(8'h3C, t1);
    release_valid();
    repeat (99) @(negedge clk);
    data_in       = 8'hC3;
    data_in_valid = 1'b1;
    repeat (50) @(negedge clk);
    data_in_valid = 1'b0;
    wait_done("change_mid");

    send_byte(8'h96, t1);
    release_valid();
    repeat (5*S + S/2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_serial", 32'(serial_out), 32'd1);
    check("rst_mid_ready", 32'(data_in_ready), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_done("rst_abort");

    send_byte(8'h55, t1);
    release_valid();
    wait_done("after_rst");

    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom_range(0, 255)), t1);
      release_valid();
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_done("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
